// File: rtl/top_manager_queued.sv
// Queues incoming tops, stalls bot input, drains the pipeline, then installs the next top with a one-cycle override pulse.
// Best case 4 cycles from push to pulse; topInReady drops when the queue is full, and the pulse waits for iready.

module top_manager_queued_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push_vld,
    input  logic [WIDTH-1:0]         i_push_dat,
    output logic                     o_push_rdy,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_push_rdy = (r_count != FULL_CNT);
    assign w_push     = i_push_vld & o_push_rdy;
    assign w_pop      = i_pop & (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

module top_manager_queued #(
    parameter int TOP_WIDTH   = 128,
    parameter int COUNT_WIDTH = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int INDEX_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [TOP_WIDTH-1:0]           topIn,
    input  logic                           topInValid,
    output logic                           topInReady,
    output logic [TOP_WIDTH-1:0]           topOut,
    output logic [INDEX_WIDTH-1:0]         topIndex,
    output logic [$clog2(QUEUE_DEPTH):0]   topsPending,
    input  logic                           botWentIn,
    output logic                           stallInput,
    input  logic                           botWentOut,
    input  logic                           iready,
    output logic                           ovalidOverride,
    output logic                           overflowError,
    output logic                           underflowError
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_WAIT_READY,
        ST_LOAD,
        ST_SETTLE
    } state_t;

    state_t                 r_state;
    logic                   r_settle_cnt;
    logic                   r_ovalid;
    logic [TOP_WIDTH-1:0]   r_top_out;
    logic [INDEX_WIDTH-1:0] r_top_index;
    logic [COUNT_WIDTH-1:0] r_in_cnt;
    logic [COUNT_WIDTH-1:0] r_out_cnt;
    logic                   r_pipe_empty;
    logic                   r_overflow;
    logic                   r_underflow;
    logic                   w_load;
    logic [TOP_WIDTH-1:0]   w_head;
    logic                   w_push_rdy;
    logic [$clog2(QUEUE_DEPTH):0] w_count;

    top_manager_queued_fifo #(
        .WIDTH (TOP_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (topInValid),
        .i_push_dat (topIn),
        .o_push_rdy (w_push_rdy),
        .i_pop      (w_load),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign w_load         = (r_state == ST_LOAD);
    assign topInReady     = w_push_rdy;
    assign topsPending    = w_count;
    assign topOut         = r_top_out;
    assign topIndex       = r_top_index;
    assign ovalidOverride = r_ovalid;
    assign overflowError  = r_overflow;
    assign underflowError = r_underflow;
    assign stallInput     = (w_count != '0) | (r_state != ST_IDLE);

    // Pulse register is raised on entry to LOAD so it mirrors the state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 1'b0;
            r_ovalid     <= 1'b0;
            r_top_out    <= '0;
            r_top_index  <= '0;
        end else begin
            r_ovalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_count != '0) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (r_pipe_empty) r_state <= ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    if (iready) begin
                        r_state  <= ST_LOAD;
                        r_ovalid <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_top_out    <= w_head;
                    r_top_index  <= r_top_index + INDEX_WIDTH'(1);
                    r_settle_cnt <= 1'b0;
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt) r_state <= ST_IDLE;
                    else              r_settle_cnt <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The LOAD clear wins over any same-cycle bot event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_pipe_empty <= 1'b1;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_load) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (botWentIn)  r_in_cnt  <= r_in_cnt + COUNT_WIDTH'(1);
                if (botWentOut) r_out_cnt <= r_out_cnt + COUNT_WIDTH'(1);
            end
            r_pipe_empty <= (r_in_cnt == r_out_cnt);
            if (topInValid && !w_push_rdy) r_overflow <= 1'b1;
            if ((r_in_cnt == r_out_cnt) && botWentOut && !botWentIn) r_underflow <= 1'b1;
        end
    end
endmodule
